stack_call_ctrl: RTL and testbench

- Initiator side of the byte-wide stack interface. Sequences CALL and RET for the core by driving the stack block's enable/decrement/increment strobes.
- CALL: pushes the 16-bit return address as two bytes, then loads the target into the PC.
- RET: pops two bytes, reassembles the return address and loads it into the PC.
- Sits between the instruction decoder and the stack block; pc_out and pc_load feed the program counter.

---
 rtl/stack_call_ctrl_pkg.sv | 28 ++
 rtl/stack_byte_sequencer.sv | 77 +++++++
 rtl/stack_call_ctrl.sv | 157 +++++++++++++++
 tb/tb_stack_call_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_call_ctrl_pkg.sv
// Shared state encoding, default widths and stack-pointer bounds for the
// CALL/RET stack initiator and its byte sequencer.
package stack_call_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    // Minimum SP that leaves room for a two-byte push, and the maximum SP
    // from which a two-byte pop cannot run off the top of the stack.
    localparam logic [15:0] SP_CALL_MIN = 16'h0002;
    localparam logic [15:0] SP_RET_MAX  = 16'hFFFD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH_HI   = 3'd1,
        ST_PUSH_LO   = 3'd2,
        ST_CALL_DONE = 3'd3,
        ST_POP_1     = 3'd4,
        ST_POP_2     = 3'd5,
        ST_POP_CAP   = 3'd6,
        ST_RET_DONE  = 3'd7
    } state_t;

    function automatic logic is_done_state(input state_t s);
        return (s == ST_CALL_DONE) || (s == ST_RET_DONE);
    endfunction

endpackage

// File: rtl/stack_byte_sequencer.sv
// Registered push/pop strobe generator for a byte-wide stack, with byte-lane
// selection for pushes and byte-lane capture/reassembly for pops.
module stack_byte_sequencer
    import stack_call_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NBYTES = 2,
    localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [SEL_W-1:0]         i_byte_sel,
    input  logic [NBYTES*DATA_W-1:0] i_word,
    input  logic                     i_cap_en,
    input  logic [SEL_W-1:0]         i_cap_sel,
    input  logic [DATA_W-1:0]        i_stk_rdata,
    output logic [NBYTES*DATA_W-1:0] o_cap_word,
    output logic                     o_stk_enable,
    output logic                     o_stk_decrement,
    output logic                     o_stk_increment,
    output logic [DATA_W-1:0]        o_stk_wdata
);

    logic [DATA_W-1:0] w_bytes [NBYTES];
    logic              r_enable;
    logic              r_decrement;
    logic              r_increment;
    logic [DATA_W-1:0] r_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic              w_cap_hit;
            logic [DATA_W-1:0] r_lane;

            assign w_bytes[gi] = i_word[gi*DATA_W +: DATA_W];
            assign w_cap_hit   = i_cap_en && (i_cap_sel == SEL_W'(gi));

            always_ff @(posedge i_clk) begin
                if (!i_reset) begin
                    r_lane <= '0;
                end else if (w_cap_hit) begin
                    r_lane <= i_stk_rdata;
                end
            end

            // The lane being captured this cycle is forwarded so the caller
            // can register the complete word on the same edge.
            assign o_cap_word[gi*DATA_W +: DATA_W] = w_cap_hit ? i_stk_rdata : r_lane;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_enable    <= 1'b0;
            r_decrement <= 1'b0;
            r_increment <= 1'b0;
            r_wdata     <= '0;
        end else begin
            // A simultaneous push+pop request issues neither strobe.
            r_enable    <= i_push ^ i_pop;
            r_decrement <= i_push & ~i_pop;
            r_increment <= i_pop & ~i_push;
            if (i_push && !i_pop) begin
                r_wdata <= w_bytes[i_byte_sel];
            end
        end
    end

    assign o_stk_enable    = r_enable;
    assign o_stk_decrement = r_decrement;
    assign o_stk_increment = r_increment;
    assign o_stk_wdata     = r_wdata;

endmodule

// File: rtl/stack_call_ctrl.sv
// CALL/RET sequencer: pushes/pops a return address as bytes through the stack
// block and produces a one-cycle PC load with the new program counter.
module stack_call_ctrl
    import stack_call_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_call_req,
    input  logic              i_ret_req,
    input  logic [ADDR_W-1:0] i_target_addr,
    input  logic [ADDR_W-1:0] i_ret_addr_in,
    output logic              o_busy,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic              o_stk_err,
    output logic              o_stk_enable,
    output logic              o_stk_decrement,
    output logic              o_stk_increment,
    output logic [DATA_W-1:0] o_stk_wdata,
    input  logic [DATA_W-1:0] i_stk_rdata,
    input  logic [ADDR_W-1:0] i_sp_in
);

    localparam int NBYTES = ADDR_W / DATA_W;
    localparam int SEL_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ADDR_W-1:0] SP_LO = ADDR_W'(SP_CALL_MIN);
    localparam logic [ADDR_W-1:0] SP_HI = ADDR_W'(SP_RET_MAX);
    localparam logic [SEL_W-1:0]  SEL_MSB = SEL_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] r_ret_addr;
    logic              r_busy;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_pc_out;
    logic              r_stk_err;

    logic              w_accept_call;
    logic              w_refuse;
    logic              w_push;
    logic              w_pop;
    logic [SEL_W-1:0]  w_byte_sel;
    logic [ADDR_W-1:0] w_push_word;
    logic              w_cap_en;
    logic [SEL_W-1:0]  w_cap_sel;
    logic [ADDR_W-1:0] w_cap_word;
    logic              w_busy_next;
    logic              w_pc_load_next;
    logic [ADDR_W-1:0] w_pc_out_next;
    logic              w_err_next;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_ret_addr <= '0;
            r_busy     <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_out   <= '0;
            r_stk_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= w_busy_next;
            r_pc_load <= w_pc_load_next;
            r_pc_out  <= w_pc_out_next;
            r_stk_err <= w_err_next;
            if (w_accept_call) begin
                r_target   <= i_target_addr;
                r_ret_addr <= i_ret_addr_in;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept_call = 1'b0;
        w_refuse      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // CALL has priority; the SP is checked only here.
                if (i_call_req) begin
                    if (i_sp_in >= SP_LO) begin
                        w_accept_call = 1'b1;
                        w_state_next  = ST_PUSH_HI;
                    end else begin
                        w_refuse = 1'b1;
                    end
                end else if (i_ret_req) begin
                    if (i_sp_in <= SP_HI) begin
                        w_state_next = ST_POP_1;
                    end else begin
                        w_refuse = 1'b1;
                    end
                end
            end
            ST_PUSH_HI:   w_state_next = ST_PUSH_LO;
            ST_PUSH_LO:   w_state_next = ST_CALL_DONE;
            ST_CALL_DONE: w_state_next = ST_IDLE;
            ST_POP_1:     w_state_next = ST_POP_2;
            ST_POP_2:     w_state_next = ST_POP_CAP;
            ST_POP_CAP:   w_state_next = ST_RET_DONE;
            ST_RET_DONE:  w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_push      = (w_state_next == ST_PUSH_HI) || (w_state_next == ST_PUSH_LO);
        w_pop       = (w_state_next == ST_POP_1) || (w_state_next == ST_POP_2);
        w_byte_sel  = (w_state_next == ST_PUSH_HI) ? SEL_MSB : '0;
        w_push_word = (r_state == ST_IDLE) ? i_ret_addr_in : r_ret_addr;

        // First popped byte is the low byte, second is the high byte.
        w_cap_en  = (r_state == ST_POP_2) || (r_state == ST_POP_CAP);
        w_cap_sel = (r_state == ST_POP_CAP) ? SEL_MSB : '0;

        w_busy_next    = (w_state_next != ST_IDLE);
        w_pc_load_next = is_done_state(w_state_next);
        w_err_next     = r_stk_err | w_refuse;
        w_pc_out_next  = r_pc_out;
        if (w_state_next == ST_CALL_DONE) begin
            w_pc_out_next = r_target;
        end else if (w_state_next == ST_RET_DONE) begin
            w_pc_out_next = w_cap_word;
        end
    end

    stack_byte_sequencer #(
        .DATA_W (DATA_W),
        .NBYTES (NBYTES)
    ) u_seq (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_push          (w_push),
        .i_pop           (w_pop),
        .i_byte_sel      (w_byte_sel),
        .i_word          (w_push_word),
        .i_cap_en        (w_cap_en),
        .i_cap_sel       (w_cap_sel),
        .i_stk_rdata     (i_stk_rdata),
        .o_cap_word      (w_cap_word),
        .o_stk_enable    (o_stk_enable),
        .o_stk_decrement (o_stk_decrement),
        .o_stk_increment (o_stk_increment),
        .o_stk_wdata     (o_stk_wdata)
    );

    assign o_busy    = r_busy;
    assign o_pc_load = r_pc_load;
    assign o_pc_out  = r_pc_out;
    assign o_stk_err = r_stk_err;

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Self-checking bench for stack_call_ctrl against a byte-stack memory model
// and a LIFO of expected return addresses.
module tb_stack_call_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        call_req;
    logic        ret_req;
    logic [15:0] target_addr;
    logic [15:0] ret_addr_in;
    logic        busy;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        stk_err;
    logic        stk_enable;
    logic        stk_decrement;
    logic        stk_increment;
    logic [7:0]  stk_wdata;
    logic [7:0]  stk_rdata;
    logic [15:0] sp_in;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_pc;
    logic        exp_err;
    logic [15:0] ret_q [$];

    // Byte-stack model: push writes mem[SP] then SP-1; pop returns mem[SP+1]
    // the following cycle then SP+1.
    logic [7:0]  stack_mem [0:65535];
    logic [15:0] model_sp;
    logic [7:0]  model_rdata;
    logic        sp_load_req;
    logic [15:0] sp_load_val;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sp_load_req) begin
            model_sp <= sp_load_val;
        end else if (stk_enable && stk_decrement) begin
            stack_mem[model_sp] <= stk_wdata;
            model_sp            <= model_sp - 16'd1;
        end else if (stk_enable && stk_increment) begin
            model_rdata <= stack_mem[model_sp + 16'd1];
            model_sp    <= model_sp + 16'd1;
        end
    end

    assign sp_in     = model_sp;
    assign stk_rdata = model_rdata;

    stack_call_ctrl dut (
        .i_clk           (clk),
        .i_reset         (reset_n),
        .i_call_req      (call_req),
        .i_ret_req       (ret_req),
        .i_target_addr   (target_addr),
        .i_ret_addr_in   (ret_addr_in),
        .o_busy          (busy),
        .o_pc_load       (pc_load),
        .o_pc_out        (pc_out),
        .o_stk_err       (stk_err),
        .o_stk_enable    (stk_enable),
        .o_stk_decrement (stk_decrement),
        .o_stk_increment (stk_increment),
        .o_stk_wdata     (stk_wdata),
        .i_stk_rdata     (stk_rdata),
        .i_sp_in         (sp_in)
    );

    task automatic set_sp(input logic [15:0] v);
        @(negedge clk);
        sp_load_req = 1'b1;
        sp_load_val = v;
        @(negedge clk);
        sp_load_req = 1'b0;
        ret_q.delete();
    endtask

    // Drives one request in the idle cycle and checks every following cycle.
    task automatic do_req(input logic c, input logic r, input logic [15:0] tgt,
                          input logic [15:0] ra, input int inject_at);
        int          kind;
        int          len;
        logic [15:0] ret_pc;
        logic [21:0] obs;
        logic [21:0] exp_v;
        logic [7:0]  want;
        @(negedge clk);
        n_vec++;
        obs   = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err, pc_out};
        exp_v = {5'b00000, exp_err, exp_pc};
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL idle_before_req: got %h want %h", obs, exp_v);
        end
        if (c) kind = (sp_in >= 16'd2) ? 1 : 0;
        else   kind = (sp_in <= 16'hFFFD) ? 2 : 0;
        ret_pc = 16'h0000;
        if (kind == 1) ret_q.push_back(ra);
        if (kind == 2 && ret_q.size() > 0) ret_pc = ret_q.pop_back();
        if (kind == 0) exp_err = 1'b1;
        len = (kind == 1) ? 3 : (kind == 2) ? 4 : 1;
        call_req    = c;
        ret_req     = r;
        target_addr = tgt;
        ret_addr_in = ra;
        for (int cyc = 1; cyc <= len; cyc++) begin
            @(negedge clk);
            call_req    = 1'b0;
            ret_req     = (cyc == inject_at);
            target_addr = 16'($urandom);
            ret_addr_in = 16'($urandom);
            exp_v        = '0;
            exp_v[21]    = (kind != 0);
            exp_v[16]    = exp_err;
            if (kind == 1 && cyc <= 2) exp_v[19:18] = 2'b11;
            if (kind == 2 && cyc <= 2) begin
                exp_v[19] = 1'b1;
                exp_v[17] = 1'b1;
            end
            if ((kind == 1 && cyc == 3) || (kind == 2 && cyc == 4)) begin
                exp_v[20] = 1'b1;
                exp_pc    = (kind == 1) ? tgt : ret_pc;
            end
            exp_v[15:0] = exp_pc;
            obs = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err, pc_out};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL seq_kind%0d_cyc%0d: got %h want %h", kind, cyc, obs, exp_v);
            end
            if (kind == 1 && cyc <= 2) begin
                want = (cyc == 1) ? ra[15:8] : ra[7:0];
                n_vec++;
                if (stk_wdata !== want) begin
                    n_err++;
                    $display("FAIL push_data_cyc%0d: got %h want %h", cyc, stk_wdata, want);
                end
            end
        end
        if (inject_at == len) begin
            @(posedge clk);
            #1 ret_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [5:0]  f;
        logic [23:0] d;
        reset_n     = 1'b0;
        call_req    = 1'b1;
        ret_req     = 1'b0;
        target_addr = 16'hABCD;
        ret_addr_in = 16'h1234;
        sp_load_req = 1'b1;
        sp_load_val = 16'h0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        f = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err};
        n_vec++;
        if (f !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000000", f);
        end
        d = {pc_out, stk_wdata};
        n_vec++;
        if (d !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 000000", d);
        end
        call_req    = 1'b0;
        sp_load_req = 1'b0;
        reset_n     = 1'b1;
        exp_pc      = 16'h0000;
        exp_err     = 1'b0;
        ret_q.delete();
    endtask

    task automatic test_call();
        set_sp(16'h0100);
        do_req(1'b1, 1'b0, 16'hABCD, 16'h1234, 0);
    endtask

    task automatic test_round_trip();
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_simultaneous();
        do_req(1'b1, 1'b1, 16'h2468, 16'hC0DE, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_ignored();
        logic [4:0] f;
        do_req(1'b1, 1'b0, 16'h1357, 16'hBEEF, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            f = {busy, pc_load, stk_enable, stk_decrement, stk_increment};
            n_vec++;
            if (f !== 5'b0) begin
                n_err++;
                $display("FAIL ignored_ret_idle%0d: got %b want 00000", k, f);
            end
        end
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_back_to_back();
        set_sp(16'h0300);
        do_req(1'b1, 1'b0, 16'h1111, 16'hA1A1, 0);
        do_req(1'b1, 1'b0, 16'h2222, 16'hB2B2, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_random();
        logic go_call;
        set_sp(16'h0800);
        for (int i = 0; i < 40; i++) begin
            go_call = (ret_q.size() == 0) ||
                      (ret_q.size() < 12 && $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (go_call)
                do_req(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)));
            else
                do_req(1'b0, 1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
        end
        while (ret_q.size() > 0) do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_boundaries();
        set_sp(16'h0002);
        do_req(1'b1, 1'b0, 16'h0F00, 16'h7788, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        set_sp(16'hFFFF);
        do_req(1'b1, 1'b0, 16'h0F11, 16'h99AA, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        set_sp(16'h0001);
        do_req(1'b1, 1'b0, 16'h5555, 16'h6666, 0);
        set_sp(16'h0000);
        do_req(1'b1, 1'b1, 16'h5555, 16'h6666, 0);
        set_sp(16'hFFFE);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        set_sp(16'hFFFF);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        set_sp(16'h0400);
        do_req(1'b1, 1'b0, 16'h0123, 16'h4567, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    task automatic test_reset_mid();
        logic [5:0]  f;
        logic [39:0] d;
        set_sp(16'h0200);
        do_req(1'b1, 1'b0, 16'h0F0F, 16'h5A5A, 0);
        @(negedge clk);
        ret_req = 1'b1;
        @(negedge clk);
        ret_req = 1'b0;
        f = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err};
        n_vec++;
        if (f !== {5'b10101, exp_err}) begin
            n_err++;
            $display("FAIL mid_pop1: got %b want %b", f, {5'b10101, exp_err});
        end
        @(negedge clk);
        f = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err};
        n_vec++;
        if (f !== {5'b10101, exp_err}) begin
            n_err++;
            $display("FAIL mid_pop2: got %b want %b", f, {5'b10101, exp_err});
        end
        reset_n = 1'b0;
        @(negedge clk);
        d = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err,
             2'b00, pc_out, stk_wdata, 8'h00};
        n_vec++;
        if (d !== 40'h0) begin
            n_err++;
            $display("FAIL mid_reset_state: got %h want 0000000000", d);
        end
        reset_n = 1'b1;
        exp_err = 1'b0;
        exp_pc  = 16'h0000;
        ret_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            f = {busy, pc_load, stk_enable, stk_decrement, stk_increment, stk_err};
            n_vec++;
            if (f !== 6'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet%0d: got %b want 000000", k, f);
            end
        end
        do_req(1'b1, 1'b0, 16'h4321, 16'h8765, 0);
        do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    endtask

    initial begin
        test_reset();
        test_call();
        test_round_trip();
        test_simultaneous();
        test_ignored();
        test_back_to_back();
        test_random();
        test_boundaries();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
